sopc_imem_ctrl: RTL and testbench
=================================

Name: sopc_imem_ctrl

Overview:
- Parametrised instruction-fetch controller between the openmips fetch port and a multi-cycle instruction ROM.
- Replaces the direct CPU-to-ROM wire of the minimal SOPC.
- Adds configurable ROM wait states, a stall handshake to the CPU, and a small direct-mapped fetch buffer so repeated fetches hit without a ROM access.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, instruction width.
- WAIT_CYCLES, 2, extra ROM cycles beyond the first; ROM data is valid at the end of the (WAIT_CYCLES+1)th cycle of rom_ce high.
- LINES, 4, fetch-buffer entries; power of 2, at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cpu_ce  in  1  CPU fetch request.
- cpu_addr  in  AW  fetch byte address; bits [1:0] ignored.
- cpu_inst  out  DW  fetched instruction.
- cpu_stall  out  1  CPU must hold cpu_addr and retry.
- flush  in  1  invalidate all buffer lines.
- rom_ce  out  1  ROM enable.
- rom_addr  out  AW  ROM byte address, word aligned.
- rom_data  in  DW  ROM read data.

Behaviour:
- Reset (rst=0, async):
  - state IDLE, all line valids 0, counter 0.
  - rom_ce=0, rom_addr=0, cpu_inst=0.
  - cpu_stall=0 while cpu_ce=0.
- Address split:
  - index = addr[IDX+1:2], with IDX = log2(LINES).
  - tag = addr[AW-1:IDX+2].
- hit = cpu_ce & valid[index] & (tag_mem[index]==tag).
- Combinational outputs:
  - cpu_stall = cpu_ce & ~hit.
  - cpu_inst = hit ? data_mem[index] : 0. A value of 0 is the NOP.
- IDLE state:
  - cpu_ce & ~hit -> latch {cpu_addr[AW-1:2],2'b00} into rom_addr, load counter with WAIT_CYCLES, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT state:
  - rom_ce=1 and rom_addr is held stable.
  - If counter != 0: decrement.
  - If counter == 0: write rom_data and the tag of the latched address into the line, set valid, go to IDLE.
  - rom_ce is deasserted on the next cycle.
- Miss latency:
  - cpu_stall is high for WAIT_CYCLES+2 cycles.
  - rom_ce is high for WAIT_CYCLES+1 cycles.
  - The hit is presented in the cycle after the fill.
- A hit in IDLE costs zero stall cycles and does not assert rom_ce.
- cpu_ce dropped or cpu_addr changed during WAIT: the fetch completes and fills the line for the latched address. The new address is evaluated in IDLE.
- flush:
  - Clears all valids on the next edge.
  - If flush coincides with the fill edge, flush wins and the filled line stays invalid.
  - A flush earlier in WAIT does not abort the fetch; the fill then writes the line valid.
- Conflict: a fill replaces the line at its index unconditionally.
- Reset during WAIT: state returns to IDLE and rom_ce drops immediately. The in-flight fetch is discarded.

Optional Feature:
- Macro: SOPC_IMEM_SEQ_PREFETCH_EN.
- Defined:
  - After each demand fill of address A, if line(A+4) misses and cpu_ce=0 or hit, enter PREF.
  - PREF performs the same WAIT sequence for A+4 and fills that line.
  - A demand miss arriving during PREF stalls until PREF completes, then issues normally. If A+4 was the missed address, it now hits.
  - Flush aborts nothing; the PREF fill is subject to the same flush-wins rule.
- Undefined: no PREF state and no prefetch logic; behaviour is exactly as above.

Decomposition:
- sopc_pkg holds:
  - the state enum (IDLE, WAIT, PREF);
  - NOP_INST = 0;
  - WORD_OFFSET = 2;
  - clog2 helper.
- Sub-module imem_line_buf holds the valid/tag/data arrays with:
  - a write port (index, tag, data);
  - a global flush;
  - a combinational read and hit output.
- The FSM and counter live in sopc_imem_ctrl.

Test Plan:
- Reset, then release with cpu_ce=0 -> rom_ce=0, cpu_inst=0, cpu_stall=0. Then cpu_ce=1 to 0x0 -> cpu_stall=1 that cycle.
- Cold miss at 0x00000010, rom_data=0x3C010001, WAIT_CYCLES=2 -> stall 4 cycles; rom_ce high 3 cycles with rom_addr=0x10; then cpu_inst=0x3C010001 with stall=0.
- Repeat fetch of 0x10 -> zero stall, rom_ce stays 0. Fetch 0x50 (same index, LINES=4) -> miss and evict; 0x10 then misses again.
- flush asserted exactly on the fill edge for 0x14 -> line invalid; next fetch of 0x14 misses with 4 stall cycles.
- rst pulled low during WAIT counter=1 -> rom_ce=0 immediately. After release, fetch of the same address misses.
- With SOPC_IMEM_SEQ_PREFETCH_EN: fill 0x20 with cpu_ce=0 afterwards -> PREF issues rom_addr=0x24. A later fetch of 0x24 hits with zero stall.

Source files
------------

// File: rtl/sopc_pkg.sv
// ---------------------------------------------------------------------------
// sopc_pkg
// Shared definitions for the instruction-fetch controller slice.
//   state_e     : fetch FSM states (IDLE, WAIT, PREF)
//   NOP_INST    : instruction word returned while no hit is presented
//   WORD_OFFSET : number of byte-offset bits inside a 32-bit word
//   clog2       : ceiling log2 helper for parameter arithmetic
// ---------------------------------------------------------------------------
package sopc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PREF = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST    = 32'h0000_0000;
  localparam int          WORD_OFFSET = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_line_buf.sv
// ---------------------------------------------------------------------------
// imem_line_buf
// Direct-mapped fetch buffer: valid/tag/data arrays with one write port,
// a global flush and NRD combinational lookup ports.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (clears valids)
//   flush         : clear every valid bit on the next edge (beats a write)
//   wr_en         : write wr_tag/wr_data into line wr_idx and mark it valid
//   rd_idx/rd_tag : lookup index/tag per read port
//   rd_hit        : per-port hit (valid and tag match)
//   rd_data       : data of the line addressed by read port 0
// ---------------------------------------------------------------------------
module imem_line_buf
  import sopc_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IW    = 2,
  parameter int TW    = 28,
  parameter int DW    = 32,
  parameter int NRD   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [TW-1:0]           wr_tag,
  input  logic [DW-1:0]           wr_data,
  input  logic [NRD-1:0][IW-1:0]  rd_idx,
  input  logic [NRD-1:0][TW-1:0]  rd_tag,
  output logic [NRD-1:0]          rd_hit,
  output logic [DW-1:0]           rd_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [TW-1:0]    tag_d  [LINES];
  logic [DW-1:0]    data_q [LINES];
  logic [DW-1:0]    data_d [LINES];

  // Flush is applied after the write so a coincident fill ends up invalid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rd_hit[r] = valid_q[rd_idx[r]] && (tag_q[rd_idx[r]] == rd_tag[r]);
    end
    rd_data = data_q[rd_idx[0]];
  end

endmodule

// File: rtl/sopc_imem_ctrl.sv
// ---------------------------------------------------------------------------
// sopc_imem_ctrl
// Instruction-fetch controller between the CPU fetch port and a multi-cycle
// ROM. Hits in the fetch buffer are served combinationally with no stall;
// misses hold the CPU while the ROM is read for WAIT_CYCLES+1 cycles.
// Optional feature macro: SOPC_IMEM_SEQ_PREFETCH_EN (sequential prefetch of
// the next word after each demand fill).
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   cpu_ce     : CPU fetch request
//   cpu_addr   : fetch byte address (bits [1:0] ignored)
//   cpu_inst   : fetched instruction, NOP when not hitting
//   cpu_stall  : CPU must hold its address and retry
//   flush      : invalidate every buffer line
//   rom_ce     : ROM enable
//   rom_addr   : word-aligned ROM byte address
//   rom_data   : ROM read data
// ---------------------------------------------------------------------------
module sopc_imem_ctrl
  import sopc_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int LINES       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_ce,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_inst,
  output logic          cpu_stall,
  input  logic          flush,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam int IDX = clog2(LINES);
  localparam int IW  = (IDX > 0) ? IDX : 1;
  localparam int TW  = AW - IDX - WORD_OFFSET;
  localparam int CW  = (clog2(WAIT_CYCLES + 1) > 0) ? clog2(WAIT_CYCLES + 1) : 1;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
  localparam int NRD = 2;
`else
  localparam int NRD = 1;
`endif

  // A single-line buffer has no index bits; every address maps to line 0.
  function automatic logic [IW-1:0] idx_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> WORD_OFFSET;
    return (IDX == 0) ? '0 : s[IW-1:0];
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> (WORD_OFFSET + IDX);
    return s[TW-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rom_ce_q, rom_ce_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            wr_en;
  logic [NRD-1:0][IW-1:0] rd_idx;
  logic [NRD-1:0][TW-1:0] rd_tag;
  logic [NRD-1:0]  rd_hit;
  logic [DW-1:0]   rd_data;
  logic            hit;

  assign rd_idx[0] = idx_of(cpu_addr);
  assign rd_tag[0] = tag_of(cpu_addr);

`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
  logic            pend_q, pend_d;
  logic [AW-1:0]   pref_addr;

  // The probe port looks up the word after the most recent demand fill,
  // whose address is still held in rom_addr while the FSM sits in IDLE.
  assign pref_addr = rom_addr_q + AW'(4);
  assign rd_idx[1] = idx_of(pref_addr);
  assign rd_tag[1] = tag_of(pref_addr);
`endif

  imem_line_buf #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW),
    .DW    (DW),
    .NRD   (NRD)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_idx  (idx_of(rom_addr_q)),
    .wr_tag  (tag_of(rom_addr_q)),
    .wr_data (rom_data),
    .rd_idx  (rd_idx),
    .rd_tag  (rd_tag),
    .rd_hit  (rd_hit),
    .rd_data (rd_data)
  );

  assign hit       = cpu_ce & rd_hit[0];
  assign cpu_stall = cpu_ce & ~hit;
  assign cpu_inst  = hit ? rd_data : DW'(NOP_INST);
  assign rom_ce    = rom_ce_q;
  assign rom_addr  = rom_addr_q;

  // WAIT and PREF share the countdown; the line is written on the edge where
  // the counter is already zero, which is the last cycle of rom_ce.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_ce_d   = rom_ce_q;
    rom_addr_d = rom_addr_q;
    wr_en      = 1'b0;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
    pend_d     = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_stall) begin
          rom_addr_d = {cpu_addr[AW-1:2], 2'b00};
          cnt_d      = CW'(WAIT_CYCLES);
          rom_ce_d   = 1'b1;
          state_d    = WAIT;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
          pend_d     = 1'b0;
        end else if (pend_q) begin
          pend_d = 1'b0;
          if (!rd_hit[1]) begin
            rom_addr_d = pref_addr;
            cnt_d      = CW'(WAIT_CYCLES);
            rom_ce_d   = 1'b1;
            state_d    = PREF;
          end
`endif
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          wr_en    = 1'b1;
          rom_ce_d = 1'b0;
          state_d  = IDLE;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
          pend_d   = (state_q == WAIT);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
`ifdef SOPC_IMEM_SEQ_PREFETCH_EN
      pend_q     <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_sopc_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sopc_imem_ctrl
// Self-checking bench for sopc_imem_ctrl in its default build. A behavioural
// model (line contents by full word address, plus an outstanding-read
// countdown) predicts stall, instruction and ROM outputs every cycle.
// The ROM model only drives correct data in the last rom_ce cycle.
// ---------------------------------------------------------------------------
module tb_sopc_imem_ctrl;

  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int WAIT_CYCLES = 2;
  localparam int LINES       = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_ce;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_inst;
  logic          cpu_stall;
  logic          flush;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int nChecks = 0;
  int nFails  = 0;
  int ceRun   = 0;
  int romCeSeen = 0;

  // Reference model state
  bit          mValid    [LINES];
  logic [31:0] mLineAddr [LINES];
  logic [31:0] mData     [LINES];
  bit          mBusy;
  int          mLeft;
  logic [31:0] mBusyAddr;
  logic [31:0] mRomAddr;

  sopc_imem_ctrl #(
    .AW          (AW),
    .DW          (DW),
    .WAIT_CYCLES (WAIT_CYCLES),
    .LINES       (LINES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_addr  (cpu_addr),
    .cpu_inst  (cpu_inst),
    .cpu_stall (cpu_stall),
    .flush     (flush),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ROM contents: one fixed word from the test plan, a hash elsewhere.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h3C01_0001;
    return ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000) | 32'h1;
  endfunction

  function automatic int lineOf(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    mBusy    = 1'b0;
    mLeft    = 0;
    mRomAddr = '0;
    ceRun    = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, let the ROM model
  // respond, compare against the model, then advance the model by one edge.
  task automatic applyStimulus(input bit ce, input logic [31:0] a, input bit fl,
                               output bit st, output logic [31:0] inst);
    logic [31:0] waddr;
    int          li;
    bit          eHit;
    bit          eStall;
    logic [31:0] eInst;
    cpu_ce   = ce;
    cpu_addr = a;
    flush    = fl;
    if (rom_ce) begin
      rom_data = (ceRun == WAIT_CYCLES) ? romWord(rom_addr) : $urandom;
      ceRun++;
      romCeSeen++;
    end else begin
      ceRun    = 0;
      rom_data = $urandom;
    end
    #1;
    waddr  = {a[31:2], 2'b00};
    li     = lineOf(waddr);
    eHit   = ce && mValid[li] && (mLineAddr[li] == waddr);
    eStall = ce && !eHit;
    eInst  = eHit ? mData[li] : 32'h0;
    checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, eStall});
    checkOutput("cpu_inst", cpu_inst, eInst);
    checkOutput("rom_ce", {31'b0, rom_ce}, {31'b0, mBusy});
    checkOutput("rom_addr", rom_addr, mRomAddr);
    st   = cpu_stall;
    inst = cpu_inst;
    if (mBusy) begin
      mLeft--;
      if (mLeft == 0) begin
        mValid[lineOf(mBusyAddr)]    = 1'b1;
        mLineAddr[lineOf(mBusyAddr)] = mBusyAddr;
        mData[lineOf(mBusyAddr)]     = romWord(mBusyAddr);
        mBusy = 1'b0;
      end
    end else if (eStall) begin
      mBusy     = 1'b1;
      mBusyAddr = waddr;
      mRomAddr  = waddr;
      mLeft     = WAIT_CYCLES + 1;
    end
    if (fl) for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    @(negedge clk);
  endtask

  // Keep fetching one address until it is served; reports stalled cycles.
  task automatic fetchUntilHit(input logic [31:0] a, output int stalls, output logic [31:0] inst);
    bit st;
    bit done;
    stalls    = 0;
    done      = 1'b0;
    romCeSeen = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, a, 1'b0, st, inst);
      if (!st) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) checkOutput("fetch_timeout", 32'h0, 32'h1);
  endtask

  task automatic drainIdle();
    bit st;
    logic [31:0] inst;
    for (int k = 0; k < 20; k++) begin
      if (!mBusy) break;
      applyStimulus(1'b0, 32'h0, 1'b0, st, inst);
    end
    if (mBusy) checkOutput("drain_timeout", 32'h0, 32'h1);
  endtask

  // Directed test-plan scenarios followed by a randomized fetch stream.
  initial begin
    bit          st;
    bit          lastStall;
    int          stalls;
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] base;
    bit          ce;
    bit          fl;

    rst      = 1'b0;
    cpu_ce   = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    rom_data = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_rom_ce", {31'b0, rom_ce}, 32'h0);
    checkOutput("reset_rom_addr", rom_addr, 32'h0);
    checkOutput("reset_cpu_inst", cpu_inst, 32'h0);
    checkOutput("reset_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, st, inst);
    applyStimulus(1'b1, 32'h0, 1'b0, st, inst);
    checkOutput("first_fetch_stall", {31'b0, st}, 32'h1);
    drainIdle();

    // Cold miss at 0x10, then a repeat hit.
    fetchUntilHit(32'h0000_0010, stalls, inst);
    checkOutput("miss_stall_cycles", stalls, WAIT_CYCLES + 2);
    checkOutput("miss_rom_ce_cycles", romCeSeen, WAIT_CYCLES + 1);
    checkOutput("miss_inst", inst, 32'h3C01_0001);
    fetchUntilHit(32'h0000_0010, stalls, inst);
    checkOutput("hit_stall_cycles", stalls, 0);
    checkOutput("hit_rom_ce_cycles", romCeSeen, 0);

    // Same-index conflict evicts 0x10.
    fetchUntilHit(32'h0000_0050, stalls, inst);
    checkOutput("evict_stall_cycles", stalls, WAIT_CYCLES + 2);
    fetchUntilHit(32'h0000_0010, stalls, inst);
    checkOutput("refetch_stall_cycles", stalls, WAIT_CYCLES + 2);

    // Flush on the fill edge leaves the line invalid.
    applyStimulus(1'b1, 32'h0000_0014, 1'b0, st, inst);
    for (int k = 0; k < WAIT_CYCLES; k++) applyStimulus(1'b1, 32'h0000_0014, 1'b0, st, inst);
    applyStimulus(1'b1, 32'h0000_0014, 1'b1, st, inst);
    fetchUntilHit(32'h0000_0014, stalls, inst);
    checkOutput("flush_fill_stall_cycles", stalls, WAIT_CYCLES + 2);

    // Flush early in the read does not abort the fill.
    applyStimulus(1'b1, 32'h0000_0018, 1'b0, st, inst);
    applyStimulus(1'b1, 32'h0000_0018, 1'b1, st, inst);
    fetchUntilHit(32'h0000_0018, stalls, inst);
    checkOutput("early_flush_stall_cycles", stalls, WAIT_CYCLES);

    // Reset while the counter is at 1 drops rom_ce at once.
    applyStimulus(1'b1, 32'h0000_001C, 1'b0, st, inst);
    applyStimulus(1'b1, 32'h0000_001C, 1'b0, st, inst);
    rst = 1'b0;
    #1;
    checkOutput("midwait_rst_rom_ce", {31'b0, rom_ce}, 32'h0);
    checkOutput("midwait_rst_rom_addr", rom_addr, 32'h0);
    checkOutput("midwait_rst_stall", {31'b0, cpu_stall}, 32'h1);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    fetchUntilHit(32'h0000_001C, stalls, inst);
    checkOutput("post_rst_stall_cycles", stalls, WAIT_CYCLES + 2);

    // Random fetch stream; a stalled CPU usually holds its address.
    lastStall = 1'b0;
    a = 32'h0;
    for (int n = 0; n < 800; n++) begin
      ce = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 29) == 0);
      if (!(lastStall && $urandom_range(0, 9) < 8)) begin
        case ($urandom_range(0, 2))
          0:       base = 32'h0000_0000;
          1:       base = 32'h8000_0000;
          default: base = 32'h0000_1000;
        endcase
        a = base + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      end
      applyStimulus(ce, a, fl, st, inst);
      lastStall = st;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
